// File: rtl/i2c_txn_sched_pkg.sv
// Shared types for the I2C transaction scheduler: FMT FIFO entry layout and FSM states.
package i2c_txn_sched_pkg;

  localparam int FmtWidth = 13;

  typedef struct packed {
    logic       nakok;
    logic       rcont;
    logic       readb;
    logic       stop;
    logic       start;
    logic [7:0] fmtbyte;
  } fmt_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RDCMD,
    ST_WAIT_CMPL
  } state_e;

endpackage

// File: rtl/i2c_txn_rr_arb.sv
// Round-robin grant among NumReq requesters; the priority pointer moves only on an accepted grant.
module i2c_txn_rr_arb #(
  parameter int NumReq = 2,
  parameter int IdW    = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req,
  input  logic              accept,
  output logic              grant_valid,
  output logic [IdW-1:0]    grant_id
);

  logic [IdW-1:0] ptr_reg;
  int             idx;

  // Scan from the highest offset down so the requester nearest the pointer wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      idx = (int'(ptr_reg) + i) % NumReq;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = IdW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_reg <= '0;
    end else if (accept) begin
      ptr_reg <= (grant_id == IdW'(NumReq - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_txn_sched.sv
// Schedules requester transactions into I2C controller FMT entries.
// Optional completion watchdog: define I2C_TXN_SCHED_TIMEOUT_EN.
module i2c_txn_sched
  import i2c_txn_sched_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 100000,
  parameter int IdW           = $clog2(NumReq)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic [NumReq-1:0][6:0]   req_addr_i,
  input  logic [NumReq-1:0]        req_read_i,
  input  logic [NumReq-1:0][7:0]   req_len_i,
  input  logic [NumReq-1:0]        wdata_valid_i,
  output logic [NumReq-1:0]        wdata_ready_o,
  input  logic [NumReq-1:0][7:0]   wdata_i,
  output logic                     fmt_valid_o,
  input  logic                     fmt_ready_i,
  output logic [FmtWidth-1:0]      fmt_data_o,
  input  logic                     cmd_complete_i,
  input  logic                     halt_i,
  output logic                     done_o,
  output logic [IdW-1:0]           done_id_o,
  output logic                     done_err_o,
  output logic                     busy_o
);

  if (NumReq < 2 || NumReq > 4 || TimeoutCycles < 1) begin : g_cfg_check
    $error("i2c_txn_sched: NumReq must be 2..4 and TimeoutCycles positive");
  end

  state_e         state_reg, state_next;
  logic [7:0]     count_reg, count_next;
  logic [6:0]     addr_reg;
  logic           read_reg;
  logic [7:0]     len_reg;
  logic [IdW-1:0] id_reg;
  logic           done_reg, done_next;
  logic           err_reg, err_next;
  logic           grant_valid, accept, last_byte, tmo_expired;
  logic [IdW-1:0] grant_id;
  fmt_entry_t     fmt_entry;

  i2c_txn_rr_arb #(.NumReq(NumReq), .IdW(IdW)) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req         (req_valid_i),
    .accept      (accept),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

`ifdef I2C_TXN_SCHED_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_cnt_reg;

  // Cleared whenever outside WAIT_CMPL, so every entry starts from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ST_WAIT_CMPL) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end else begin
      tmo_cnt_reg <= '0;
    end
  end

  assign tmo_expired = (tmo_cnt_reg == TmoW'(TimeoutCycles - 1));
`else
  assign tmo_expired = 1'b0;
`endif

  // len 0 means 256 bytes, which the 8-bit wrap of len-1 handles naturally.
  assign last_byte = (count_reg == len_reg - 8'd1);

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    accept        = 1'b0;
    fmt_entry     = '0;
    fmt_valid_o   = 1'b0;
    req_ready_o   = '0;
    wdata_ready_o = '0;
    case (state_reg)
      ST_IDLE: begin
        // The done cycle doubles as the mandatory idle gap before the next grant.
        if (grant_valid && !halt_i && !done_reg) begin
          accept                = 1'b1;
          req_ready_o[grant_id] = 1'b1;
          count_next            = '0;
          state_next            = ST_ADDR;
        end
      end
      ST_ADDR: begin
        fmt_valid_o       = 1'b1;
        fmt_entry.start   = 1'b1;
        fmt_entry.fmtbyte = {addr_reg, read_reg};
        if (fmt_ready_i) state_next = read_reg ? ST_RDCMD : ST_WDATA;
      end
      ST_WDATA: begin
        fmt_valid_o           = wdata_valid_i[id_reg];
        wdata_ready_o[id_reg] = fmt_ready_i;
        fmt_entry.fmtbyte     = wdata_i[id_reg];
        fmt_entry.stop        = last_byte;
        if (wdata_valid_i[id_reg] && fmt_ready_i) begin
          count_next = count_reg + 8'd1;
          if (last_byte) state_next = ST_WAIT_CMPL;
        end
      end
      ST_RDCMD: begin
        fmt_valid_o       = 1'b1;
        fmt_entry.readb   = 1'b1;
        fmt_entry.stop    = 1'b1;
        fmt_entry.fmtbyte = len_reg;
        if (fmt_ready_i) state_next = ST_WAIT_CMPL;
      end
      ST_WAIT_CMPL: begin
        if (cmd_complete_i) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else if (tmo_expired) begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (state_reg != ST_IDLE && halt_i) begin
      state_next = ST_IDLE;
      count_next = count_reg;
      done_next  = 1'b1;
      err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      addr_reg  <= '0;
      read_reg  <= 1'b0;
      len_reg   <= '0;
      id_reg    <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      if (accept) begin
        addr_reg <= req_addr_i[grant_id];
        read_reg <= req_read_i[grant_id];
        len_reg  <= req_len_i[grant_id];
        id_reg   <= grant_id;
      end
    end
  end

  assign fmt_data_o = fmt_entry;
  assign done_o     = done_reg;
  assign done_err_o = err_reg;
  assign done_id_o  = id_reg;
  assign busy_o     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_i2c_txn_sched.sv
// Directed self-checking bench for i2c_txn_sched; watchdog case runs when I2C_TXN_SCHED_TIMEOUT_EN is defined.
module tb_i2c_txn_sched;

  localparam int NumReq = 2;
  localparam int IdW    = 1;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NumReq-1:0]      req_valid_i, req_ready_o, req_read_i;
  logic [NumReq-1:0][6:0] req_addr_i;
  logic [NumReq-1:0][7:0] req_len_i, wdata_i;
  logic [NumReq-1:0]      wdata_valid_i, wdata_ready_o;
  logic                   fmt_valid_o, fmt_ready_i;
  logic [12:0]            fmt_data_o;
  logic                   cmd_complete_i, halt_i;
  logic                   done_o, done_err_o, busy_o;
  logic [IdW-1:0]         done_id_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0]    fmt_q [$];
  logic [IdW:0]   done_q [$];
  logic [7:0]     tx_bytes [4];

  i2c_txn_sched #(.NumReq(NumReq), .TimeoutCycles(16)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_read_i     (req_read_i),
    .req_len_i      (req_len_i),
    .wdata_valid_i  (wdata_valid_i),
    .wdata_ready_o  (wdata_ready_o),
    .wdata_i        (wdata_i),
    .fmt_valid_o    (fmt_valid_o),
    .fmt_ready_i    (fmt_ready_i),
    .fmt_data_o     (fmt_data_o),
    .cmd_complete_i (cmd_complete_i),
    .halt_i         (halt_i),
    .done_o         (done_o),
    .done_id_o      (done_id_o),
    .done_err_o     (done_err_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Accepted FMT entries and done events, sampled mid-cycle before the handshaking edge.
  always @(negedge clk_i) begin
    if (rst_ni && fmt_valid_o && fmt_ready_i) fmt_q.push_back(fmt_data_o);
    if (done_o) done_q.push_back({done_id_o, done_err_o});
  end

  task automatic idle_inputs();
    req_valid_i = '0; req_read_i = '0; req_addr_i = '0; req_len_i = '0;
    wdata_valid_i = '0; wdata_i = '0; fmt_ready_i = 1'b0;
    cmd_complete_i = 1'b0; halt_i = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    fmt_q.delete(); done_q.delete();
  endtask

  // Plays one requester through a transaction; returns at posedge+1.
  task automatic run_txn(input int id, input logic [6:0] addr, input logic rd,
                         input logic [7:0] len, input int n, input bit toggle,
                         input bit do_cmpl);
    int  k = 0;
    int  exp_n = rd ? 2 : 1 + n;
    bit  fin = 0, sent = 0, hs_req, hs_w;
    fmt_q.delete(); done_q.delete();
    req_valid_i[id] = 1'b1; req_addr_i[id] = addr; req_read_i[id] = rd; req_len_i[id] = len;
    wdata_valid_i[id] = !rd && n > 0; wdata_i[id] = tx_bytes[0];
    fmt_ready_i = !toggle;
    for (int c = 0; c < 80 && !fin; c++) begin
      @(negedge clk_i);
      hs_req = req_ready_o[id];
      hs_w   = wdata_valid_i[id] && wdata_ready_o[id];
      if (done_o) fin = 1;
      @(posedge clk_i); #1;
      cmd_complete_i = 1'b0;
      if (hs_req) req_valid_i[id] = 1'b0;
      if (hs_w) begin
        k++;
        if (k < n) wdata_i[id] = tx_bytes[k];
        else wdata_valid_i[id] = 1'b0;
      end
      if (toggle) fmt_ready_i = ~fmt_ready_i;
      if (fmt_q.size() == exp_n) begin
        if (!do_cmpl) fin = 1;
        else if (!sent) begin cmd_complete_i = 1'b1; sent = 1; end
      end
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL txn_timeout id%0d: got no completion, required completion within 80 cycles", id);
    end
    fmt_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    @(negedge clk_i);
    n_checks += 7;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy_o); end
    if (fmt_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_fmt_valid: got %b required 0", fmt_valid_o); end
    if (fmt_data_o !== 13'h0) begin n_fail++; $display("FAIL rst_fmt_data: got %h required 000", fmt_data_o); end
    if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b required 00", req_ready_o); end
    if (wdata_ready_o !== 2'b00) begin n_fail++; $display("FAIL rst_wdata_ready: got %b required 00", wdata_ready_o); end
    if (done_o !== 1'b0 || done_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b/%b required 0/0", done_o, done_err_o); end
    if (done_id_o !== 1'b0) begin n_fail++; $display("FAIL rst_done_id: got %0d required 0", done_id_o); end
    apply_reset();
  endtask

  task automatic test_write();
    tx_bytes[0] = 8'hA1; tx_bytes[1] = 8'hB2;
    run_txn(0, 7'h50, 1'b0, 8'd2, 2, 1'b0, 1'b1);
    n_checks += 4;
    if (fmt_q.size() !== 3) begin n_fail++; $display("FAIL wr_count: got %0d required 3", fmt_q.size()); end
    else begin
      if (fmt_q[0] !== 13'h1A0) begin n_fail++; $display("FAIL wr_addr_entry: got %h required 1a0", fmt_q[0]); end
      if (fmt_q[1] !== 13'h0A1) begin n_fail++; $display("FAIL wr_byte0: got %h required 0a1", fmt_q[1]); end
      if (fmt_q[2] !== 13'h2B2) begin n_fail++; $display("FAIL wr_byte1_stop: got %h required 2b2", fmt_q[2]); end
    end
    n_checks++;
    if (done_q.size() !== 1 || done_q[0] !== 2'b00) begin
      n_fail++; $display("FAIL wr_done: got %0d events first %b required 1 event {id0,err0}", done_q.size(), done_q.size() ? done_q[0] : 2'bxx);
    end
    @(negedge clk_i);
    n_checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL wr_done_single: got done=%b busy=%b required 0/0", done_o, busy_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_read();
    run_txn(1, 7'h21, 1'b1, 8'd0, 0, 1'b0, 1'b1);
    n_checks += 3;
    if (fmt_q.size() !== 2) begin n_fail++; $display("FAIL rd_count: got %0d required 2", fmt_q.size()); end
    else begin
      if (fmt_q[0] !== 13'h143) begin n_fail++; $display("FAIL rd_addr_entry: got %h required 143", fmt_q[0]); end
      if (fmt_q[1] !== 13'h600) begin n_fail++; $display("FAIL rd_cmd_entry: got %h required 600", fmt_q[1]); end
    end
    n_checks++;
    if (done_q.size() !== 1 || done_q[0] !== 2'b10) begin
      n_fail++; $display("FAIL rd_done: got %0d events first %b required 1 event {id1,err0}", done_q.size(), done_q.size() ? done_q[0] : 2'bxx);
    end
  endtask

  task automatic test_ready_toggle();
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;
    run_txn(0, 7'h3C, 1'b0, 8'd3, 3, 1'b1, 1'b1);
    n_checks += 5;
    if (fmt_q.size() !== 4) begin n_fail++; $display("FAIL tg_count: got %0d required 4", fmt_q.size()); end
    else begin
      if (fmt_q[0] !== 13'h178) begin n_fail++; $display("FAIL tg_addr_entry: got %h required 178", fmt_q[0]); end
      if (fmt_q[1] !== 13'h011) begin n_fail++; $display("FAIL tg_byte0: got %h required 011", fmt_q[1]); end
      if (fmt_q[2] !== 13'h022) begin n_fail++; $display("FAIL tg_byte1: got %h required 022", fmt_q[2]); end
      if (fmt_q[3] !== 13'h233) begin n_fail++; $display("FAIL tg_byte2_stop: got %h required 233", fmt_q[3]); end
    end
  endtask

  task automatic test_back_to_back();
    int grants [$];
    int overlap = 0;
    bit dropped = 0;
    apply_reset();
    req_valid_i = 2'b11; req_read_i = 2'b11; req_len_i[0] = 8'd1; req_len_i[1] = 8'd1;
    req_addr_i[0] = 7'h10; req_addr_i[1] = 7'h11;
    fmt_ready_i = 1'b1; cmd_complete_i = 1'b1;
    for (int c = 0; c < 60 && done_q.size() < 4; c++) begin
      @(negedge clk_i);
      if (done_o && req_ready_o != 2'b00) overlap++;
      if (req_ready_o != 2'b00) grants.push_back(req_ready_o[1] ? 1 : 0);
      @(posedge clk_i); #1;
      if (grants.size() == 4 && !dropped) begin req_valid_i = 2'b00; dropped = 1; end
    end
    cmd_complete_i = 1'b0; fmt_ready_i = 1'b0;
    n_checks += 3;
    if (grants.size() !== 4) begin n_fail++; $display("FAIL rr_grants: got %0d grants required 4", grants.size()); end
    else if (grants[0] !== 0 || grants[1] !== 1 || grants[2] !== 0 || grants[3] !== 1) begin
      n_fail++; $display("FAIL rr_order: got %0d,%0d,%0d,%0d required 0,1,0,1", grants[0], grants[1], grants[2], grants[3]);
    end
    if (done_q.size() !== 4) begin n_fail++; $display("FAIL rr_dones: got %0d required 4", done_q.size()); end
    else if (done_q[0] !== 2'b00 || done_q[1] !== 2'b10 || done_q[2] !== 2'b00 || done_q[3] !== 2'b10) begin
      n_fail++; $display("FAIL rr_done_ids: got %b,%b,%b,%b required 00,10,00,10", done_q[0], done_q[1], done_q[2], done_q[3]);
    end
    if (overlap !== 0) begin n_fail++; $display("FAIL rr_done_grant_overlap: got %0d cycles required 0", overlap); end
  endtask

  task automatic test_halt();
    apply_reset();
    req_valid_i[0] = 1'b1; req_addr_i[0] = 7'h50; req_read_i[0] = 1'b0; req_len_i[0] = 8'd3;
    wdata_valid_i[0] = 1'b1; wdata_i[0] = 8'h11; fmt_ready_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL halt_grant: got %b required 01", req_ready_o); end
    @(posedge clk_i); #1 req_valid_i[0] = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (fmt_valid_o !== 1'b1 || fmt_data_o !== 13'h1A0) begin n_fail++; $display("FAIL halt_addr: got v=%b d=%h required 1/1a0", fmt_valid_o, fmt_data_o); end
    @(posedge clk_i); #1 fmt_ready_i = 1'b0;
    @(negedge clk_i);
    n_checks += 2;
    if (fmt_valid_o !== 1'b1 || fmt_data_o !== 13'h011) begin n_fail++; $display("FAIL halt_wdata: got v=%b d=%h required 1/011", fmt_valid_o, fmt_data_o); end
    if (wdata_ready_o !== 2'b00) begin n_fail++; $display("FAIL halt_wready_stall: got %b required 00", wdata_ready_o); end
    @(posedge clk_i); #1 halt_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL halt_same_cycle: got done=%b busy=%b required 0/1", done_o, busy_o); end
    @(posedge clk_i); #1 req_valid_i[1] = 1'b1; req_read_i[1] = 1'b1; req_len_i[1] = 8'd1;
    @(negedge clk_i);
    n_checks += 3;
    if (fmt_valid_o !== 1'b0) begin n_fail++; $display("FAIL halt_fmt_drop: got %b required 0", fmt_valid_o); end
    if (done_o !== 1'b1 || done_err_o !== 1'b1 || done_id_o !== 1'b0) begin
      n_fail++; $display("FAIL halt_done: got done=%b err=%b id=%0d required 1/1/0", done_o, done_err_o, done_id_o);
    end
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL halt_busy: got %b required 0", busy_o); end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_checks++;
    if (req_ready_o !== 2'b00 || done_o !== 1'b0) begin n_fail++; $display("FAIL halt_idle_block: got ready=%b done=%b required 00/0", req_ready_o, done_o); end
    @(posedge clk_i); #1 halt_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL halt_release_grant: got %b required 10", req_ready_o); end
    @(posedge clk_i); #1 req_valid_i[1] = 1'b0; wdata_valid_i[0] = 1'b0;
    done_q.delete();
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL midtxn_busy: got %b required 1", busy_o); end
    @(posedge clk_i); #1 rst_ni = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b0 || fmt_valid_o !== 1'b0) begin n_fail++; $display("FAIL midtxn_reset: got busy=%b v=%b required 0/0", busy_o, fmt_valid_o); end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (4) @(posedge clk_i); #1;
    n_checks++;
    if (done_q.size() !== 0) begin n_fail++; $display("FAIL midtxn_no_done: got %0d done events required 0", done_q.size()); end
  endtask

  task automatic test_wait_exit();
    int n = 0;
    apply_reset();
    tx_bytes[0] = 8'h5A;
    run_txn(1, 7'h2B, 1'b0, 8'd1, 1, 1'b0, 1'b0);
`ifdef I2C_TXN_SCHED_TIMEOUT_EN
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); n++;
      @(negedge clk_i);
      if (done_o) break;
    end
    n_checks += 2;
    if (n !== 16) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles required 16", n); end
    if (done_o !== 1'b1 || done_err_o !== 1'b1 || done_id_o !== 1'b1) begin
      n_fail++; $display("FAIL tmo_done: got done=%b err=%b id=%0d required 1/1/1", done_o, done_err_o, done_id_o);
    end
    @(posedge clk_i); #1;
`else
    repeat (40) @(posedge clk_i);
    @(negedge clk_i);
    n_checks += 2;
    if (done_q.size() !== 0) begin n_fail++; $display("FAIL wait_no_exit: got %0d done events required 0", done_q.size()); end
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL wait_busy: got %b required 1", busy_o); end
    @(posedge clk_i); #1 halt_i = 1'b1;
    @(posedge clk_i); #1 halt_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (done_o !== 1'b1 || done_err_o !== 1'b1) begin n_fail++; $display("FAIL wait_halt_exit: got done=%b err=%b required 1/1", done_o, done_err_o); end
    @(posedge clk_i); #1;
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ready_toggle();
    test_back_to_back();
    test_halt();
    test_wait_exit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
